// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader
//   Boot-time loader on the write side of instruction memory. It accepts a
//   framed byte stream (LEN0, LEN1, N*4 data bytes LSB first, optional CSUM).
//   It assembles little-endian words and writes them to the memory load port.
//   The core is held in reset until a complete, verified image is written.
//
//   Optional feature macro: IMEM_LOADER_CSUM_EN
//     defined   : a trailing CSUM byte (XOR of all preceding frame bytes) is
//                 required and checked.
//     undefined : there is no CSUM byte; the load completes after the Nth word.
//
// Ports:
//   CLK, Reset      clock; synchronous active-low reset
//   Start           single-cycle pulse that arms a new load
//   RxValid/RxByte  byte source; RxReady accepts a byte (transfer on both high)
//   MemWrEn         one-cycle write strobe to instruction memory
//   MemWrAddr       word-aligned byte address of the write
//   MemWrData       assembled instruction word
//   CoreHold        holds the core in reset while no verified image is present
//   Done / Error    level status of the current or most recent load
//   WordsLoaded     words written in the current or most recent load
module imem_loader #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   RxValid,
  input  logic [7:0]             RxByte,
  output logic                   RxReady,
  output logic                   MemWrEn,
  output logic [ADDR_WIDTH-1:0]  MemWrAddr,
  output logic [WORD_LENGTH-1:0] MemWrData,
  output logic                   CoreHold,
  output logic                   Done,
  output logic                   Error,
  output logic [15:0]            WordsLoaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
`ifdef IMEM_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] words_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] word_buf_q;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]  xor_q;
`endif

  logic        accept;
  logic        clear;
  logic        word_done;
  logic        word_last;
  logic [15:0] len_full;

  assign len_full  = {RxByte, len_q[7:0]};
  assign word_last = ((words_q + 16'd1) == len_q);
  assign accept    = RxReady && RxValid;
  assign word_done = accept && (state_q == S_DATA) && (byte_idx_q == 2'd3);

  always_ff @(posedge CLK) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    RxReady  = 1'b0;
    clear    = 1'b0;
    CoreHold = 1'b1;
    Done     = 1'b0;
    Error    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_LEN0;
          clear   = 1'b1;
        end
      end
      S_LEN0: begin
        RxReady = 1'b1;
        if (RxValid) state_d = S_LEN1;
      end
      S_LEN1: begin
        RxReady = 1'b1;
        if (RxValid) begin
          if (32'(len_full) > DEPTH) state_d = S_ERR;
`ifdef IMEM_LOADER_CSUM_EN
          else if (len_full == 16'd0) state_d = S_CSUM;
`else
          else if (len_full == 16'd0) state_d = S_DONE;
`endif
          else state_d = S_DATA;
        end
      end
      S_DATA: begin
        RxReady = 1'b1;
        if (RxValid && (byte_idx_q == 2'd3) && word_last) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: begin
        RxReady = 1'b1;
        if (RxValid) state_d = (RxByte == xor_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        Done     = 1'b1;
        CoreHold = 1'b0;
        if (Start) begin
          state_d = S_LEN0;
          clear   = 1'b1;
        end
      end
      S_ERR: begin
        Error = 1'b1;
        if (Start) begin
          state_d = S_LEN0;
          clear   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The write for a word is registered off the 4th-byte acceptance, so the
  // strobe, address and data all appear together one cycle later. A reset on
  // that edge suppresses the pending write.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      MemWrEn    <= 1'b0;
      MemWrAddr  <= '0;
      MemWrData  <= '0;
      len_q      <= '0;
      words_q    <= '0;
      byte_idx_q <= '0;
      word_buf_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      MemWrEn <= word_done;
      if (word_done) begin
        MemWrAddr <= ADDR_WIDTH'({words_q, 2'b00});
        MemWrData <= WORD_LENGTH'({RxByte, word_buf_q});
      end
      if (clear) begin
        len_q      <= '0;
        words_q    <= '0;
        byte_idx_q <= '0;
        word_buf_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        xor_q      <= '0;
`endif
      end else if (accept) begin
`ifdef IMEM_LOADER_CSUM_EN
        xor_q <= xor_q ^ RxByte;
`endif
        case (state_q)
          S_LEN0: len_q[7:0]  <= RxByte;
          S_LEN1: len_q[15:8] <= RxByte;
          S_DATA: begin
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0:    word_buf_q[7:0]   <= RxByte;
              2'd1:    word_buf_q[15:8]  <= RxByte;
              2'd2:    word_buf_q[23:16] <= RxByte;
              default: words_q           <= words_q + 16'd1;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign WordsLoaded = words_q;

endmodule
